pipe_ctrl: RTL and testbench

PIPE_CTRL -- requirements
Module: pipe_ctrl

---
 rtl/pipe_ctrl_pkg.sv | 53 +++++
 rtl/pipe_ctrl.sv | 170 +++++++++++++++++
 tb/tb_pipe_ctrl.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared pipeline definitions: controller state encoding, next-PC select codes,
// the per-cycle action resolved by the controller, and the control-output bundle.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_BOOT   = 2'b00,
        ST_RUN    = 2'b01,
        ST_FREEZE = 2'b10
    } pipe_state_e;

    typedef enum logic [1:0] {
        PC_SEL_PC4 = 2'b00,
        PC_SEL_JMP = 2'b01,
        PC_SEL_BR  = 2'b10
    } pc_sel_e;

    // Action applied in a given cycle after priority resolution.
    typedef enum logic [2:0] {
        ACT_BOOT   = 3'd0,
        ACT_FREEZE = 3'd1,
        ACT_BR     = 3'd2,
        ACT_STALL  = 3'd3,
        ACT_JMP    = 3'd4,
        ACT_NORM   = 3'd5
    } pipe_act_e;

    typedef struct packed {
        logic    pc_en;
        pc_sel_e pc_sel;
        logic    ifid_en;
        logic    ifid_flush;
        logic    idexe_flush;
        logic    pipe_en;
    } pipe_ctrl_t;

    // Priority: mem_wait > branch taken > hazard stall > jump > normal.
    // Anything that is not RUN/FREEZE is treated as BOOT, which ignores inputs.
    function automatic pipe_act_e resolve_act(input pipe_state_e st,
                                              input logic        hz,
                                              input logic        jp,
                                              input logic        br,
                                              input logic        mw);
        pipe_act_e a;
        if (st != ST_RUN && st != ST_FREEZE) a = ACT_BOOT;
        else if (mw)                         a = ACT_FREEZE;
        else if (br)                         a = ACT_BR;
        else if (hz)                         a = ACT_STALL;
        else if (jp)                         a = ACT_JMP;
        else                                 a = ACT_NORM;
        return a;
    endfunction

endpackage

// File: rtl/pipe_ctrl.sv
// Pipeline hazard/redirect controller for the 5-stage core.
// Registered: state, boot counter, stall counter, sticky stall_err, perf counters.
// Control outputs are decoded combinationally from state and current inputs.
// Optional build macro PIPE_CTRL_PERF_EN adds the stall/redirect perf counters;
// without it perf_stall/perf_flush are tied to zero and no counter flops exist.
//
// state  | meaning
// BOOT   | pipeline clear for BOOT_CYC cycles after reset, inputs ignored
// RUN    | normal issue; branch/stall/jump handled combinationally
// FREEZE | data memory busy, everything held
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int STALL_MAX = 3,
    parameter int BOOT_CYC  = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        hz_stall,
    input  logic        id_jump,
    input  logic        exe_br_taken,
    input  logic        mem_wait,
    output logic        pc_en,
    output logic [1:0]  pc_sel,
    output logic        ifid_en,
    output logic        ifid_flush,
    output logic        idexe_flush,
    output logic        pipe_en,
    output logic [1:0]  state,
    output logic        stall_err,
    output logic [31:0] perf_stall,
    output logic [31:0] perf_flush
);

    // A BOOT_CYC of 0 still yields one boot cycle; the counter needs at least one bit.
    localparam int BW  = (BOOT_CYC  < 2) ? 1 : $clog2(BOOT_CYC + 1);
    localparam int SCW = (STALL_MAX < 1) ? 1 : $clog2(STALL_MAX + 1);
    localparam logic [BW-1:0]  BOOT_LAST   = BW'((BOOT_CYC > 0) ? BOOT_CYC - 1 : 0);
    localparam logic [SCW-1:0] STALL_LIMIT = SCW'(STALL_MAX);

    pipe_state_e    state_q, state_d;
    logic [BW-1:0]  boot_cnt_q, boot_cnt_d;
    logic [SCW-1:0] stall_cnt_q, stall_cnt_d;
    logic           stall_err_q, stall_err_d;
    pipe_act_e      act;
    pipe_ctrl_t     ctrl;

    assign act = resolve_act(state_q, hz_stall, id_jump, exe_br_taken, mem_wait);

    // State, boot counter and stall tracking registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_BOOT;
            boot_cnt_q  <= '0;
            stall_cnt_q <= '0;
            stall_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            boot_cnt_q  <= boot_cnt_d;
            stall_cnt_q <= stall_cnt_d;
            stall_err_q <= stall_err_d;
        end
    end

    // Next-state: leave BOOT after the last boot cycle; mem_wait decides FREEZE vs RUN.
    always_comb begin
        state_d    = state_q;
        boot_cnt_d = boot_cnt_q;
        case (state_q)
            ST_RUN, ST_FREEZE: state_d = (act == ACT_FREEZE) ? ST_FREEZE : ST_RUN;
            default: begin
                boot_cnt_d = boot_cnt_q + 1'b1;
                if (boot_cnt_q == BOOT_LAST) state_d = ST_RUN;
                else                         state_d = ST_BOOT;
            end
        endcase
    end

    // Saturating consecutive-stall count; held across freeze, cleared by any other issue.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        stall_err_d = stall_err_q;
        case (act)
            ACT_STALL: begin
                if (stall_cnt_q == STALL_LIMIT) stall_err_d = 1'b1;
                else                            stall_cnt_d = stall_cnt_q + 1'b1;
            end
            ACT_BR, ACT_JMP, ACT_NORM: stall_cnt_d = '0;
            default: ;
        endcase
    end

    // Output decode from the resolved action.
    always_comb begin
        ctrl.pc_en       = 1'b1;
        ctrl.pc_sel      = PC_SEL_PC4;
        ctrl.ifid_en     = 1'b1;
        ctrl.ifid_flush  = 1'b0;
        ctrl.idexe_flush = 1'b0;
        ctrl.pipe_en     = 1'b1;
        case (act)
            ACT_BOOT: begin
                ctrl.pc_en       = 1'b0;
                ctrl.ifid_en     = 1'b0;
                ctrl.ifid_flush  = 1'b1;
                ctrl.idexe_flush = 1'b1;
            end
            ACT_FREEZE: begin
                ctrl.pc_en   = 1'b0;
                ctrl.ifid_en = 1'b0;
                ctrl.pipe_en = 1'b0;
            end
            ACT_BR: begin
                ctrl.pc_sel      = PC_SEL_BR;
                ctrl.ifid_flush  = 1'b1;
                ctrl.idexe_flush = 1'b1;
            end
            ACT_STALL: begin
                ctrl.pc_en       = 1'b0;
                ctrl.ifid_en     = 1'b0;
                ctrl.idexe_flush = 1'b1;
            end
            ACT_JMP: begin
                ctrl.pc_sel     = PC_SEL_JMP;
                ctrl.ifid_flush = 1'b1;
            end
            default: ;
        endcase
    end

    assign pc_en       = ctrl.pc_en;
    assign pc_sel      = ctrl.pc_sel;
    assign ifid_en     = ctrl.ifid_en;
    assign ifid_flush  = ctrl.ifid_flush;
    assign idexe_flush = ctrl.idexe_flush;
    assign pipe_en     = ctrl.pipe_en;
    assign state       = state_q;
    assign stall_err   = stall_err_q;

`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] perf_stall_q, perf_stall_d;
    logic [31:0] perf_flush_q, perf_flush_d;

    // Stall cycles include freeze cycles; redirects are taken branches and jumps.
    always_comb begin
        perf_stall_d = perf_stall_q;
        perf_flush_d = perf_flush_q;
        if (act == ACT_STALL || act == ACT_FREEZE) perf_stall_d = perf_stall_q + 32'd1;
        if (act == ACT_BR || act == ACT_JMP)       perf_flush_d = perf_flush_q + 32'd1;
    end

    // Free-running perf counters, wrapping modulo 2^32.
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_stall_q <= '0;
            perf_flush_q <= '0;
        end else begin
            perf_stall_q <= perf_stall_d;
            perf_flush_q <= perf_flush_d;
        end
    end

    assign perf_stall = perf_stall_q;
    assign perf_flush = perf_flush_q;
`else
    assign perf_stall = '0;
    assign perf_flush = '0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed-vector bench for pipe_ctrl. Stimulus pushes hand-computed expectations
// into a queue; a negedge monitor pops and compares each cycle that has one.
module tb_pipe_ctrl;
    logic        clk;
    logic        rst;
    logic        hz_stall, id_jump, exe_br_taken, mem_wait;
    logic        pc_en, ifid_en, ifid_flush, idexe_flush, pipe_en, stall_err;
    logic [1:0]  pc_sel, state;
    logic [31:0] perf_stall, perf_flush;

    // ctrl = {pc_en, pc_sel[1:0], ifid_en, ifid_flush, idexe_flush, pipe_en}
    localparam logic [6:0] C_BOOT = 7'b0_00_0_1_1_1;
    localparam logic [6:0] C_FRZ  = 7'b0_00_0_0_0_0;
    localparam logic [6:0] C_BR   = 7'b1_10_1_1_1_1;
    localparam logic [6:0] C_STL  = 7'b0_00_0_0_1_1;
    localparam logic [6:0] C_JMP  = 7'b1_01_1_1_0_1;
    localparam logic [6:0] C_NORM = 7'b1_00_1_0_0_1;
    localparam logic [1:0] S_BOOT = 2'b00;
    localparam logic [1:0] S_RUN  = 2'b01;
    localparam logic [1:0] S_FRZ  = 2'b10;

    typedef struct packed {
        logic [7:0]  idx;
        logic [6:0]  ctrl;
        logic [1:0]  st;
        logic        err;
        logic [31:0] ps;
        logic [31:0] pf;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   vec_idx  = 0;

    pipe_ctrl #(.STALL_MAX(3), .BOOT_CYC(2)) dut (
        .clk(clk), .rst(rst),
        .hz_stall(hz_stall), .id_jump(id_jump),
        .exe_br_taken(exe_br_taken), .mem_wait(mem_wait),
        .pc_en(pc_en), .pc_sel(pc_sel), .ifid_en(ifid_en),
        .ifid_flush(ifid_flush), .idexe_flush(idexe_flush), .pipe_en(pipe_en),
        .state(state), .stall_err(stall_err),
        .perf_stall(perf_stall), .perf_flush(perf_flush)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] pm(input logic [31:0] v);
`ifdef PIPE_CTRL_PERF_EN
        return v;
`else
        return (v & 32'd0);
`endif
    endfunction

    task automatic check(input string nm, input int idx, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s vec=%0d actual=0x%0h required=0x%0h", nm, idx, act, req);
        end
    endtask

    // Drive one cycle of inputs after the rising edge and queue its expectation.
    task automatic step(input logic r, input logic hz, input logic jp, input logic br,
                        input logic mw, input logic chk, input logic frc,
                        input logic [6:0] c, input logic [1:0] s, input logic e,
                        input logic [31:0] ps, input logic [31:0] pf);
        exp_t x;
        @(posedge clk);
        #1;
        if (frc) begin
`ifdef PIPE_CTRL_PERF_EN
            force dut.perf_flush_q = 32'hFFFF_FFFF;
            #1;
            release dut.perf_flush_q;
`else
            #1;
`endif
        end
        rst = r; hz_stall = hz; id_jump = jp; exe_br_taken = br; mem_wait = mw;
        if (chk) begin
            x.idx  = 8'(vec_idx);
            x.ctrl = c;
            x.st   = s;
            x.err  = e;
            x.ps   = pm(ps);
            x.pf   = pm(pf);
            exp_q.push_back(x);
        end
        vec_idx++;
    endtask

    // Monitor: compare DUT outputs mid-cycle against the queued expectation.
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("ctrl",       e.idx, 32'({pc_en, pc_sel, ifid_en, ifid_flush, idexe_flush, pipe_en}), 32'(e.ctrl));
            check("state",      e.idx, 32'(state),     32'(e.st));
            check("stall_err",  e.idx, 32'(stall_err), 32'(e.err));
            check("perf_stall", e.idx, perf_stall,     e.ps);
            check("perf_flush", e.idx, perf_flush,     e.pf);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; hz_stall = 1'b0; id_jump = 1'b0; exe_br_taken = 1'b0; mem_wait = 1'b0;
        //     r  hz jp br mw chk frc ctrl    state  err ps  pf
        step(1, 0, 0, 0, 0, 0, 0, C_BOOT, S_BOOT, 0, 0, 0);
        // boot: two clear cycles, inputs ignored in the second
        step(0, 0, 0, 0, 0, 1, 0, C_BOOT, S_BOOT, 0, 0, 0);
        step(0, 1, 1, 1, 1, 1, 0, C_BOOT, S_BOOT, 0, 0, 0);
        step(0, 0, 0, 0, 0, 1, 0, C_NORM, S_RUN,  0, 0, 0);
        // three legal stalls, fourth trips stall_err
        step(0, 1, 0, 0, 0, 1, 0, C_STL,  S_RUN,  0, 0, 0);
        step(0, 1, 0, 0, 0, 1, 0, C_STL,  S_RUN,  0, 1, 0);
        step(0, 1, 0, 0, 0, 1, 0, C_STL,  S_RUN,  0, 2, 0);
        step(0, 1, 0, 0, 0, 1, 0, C_STL,  S_RUN,  0, 3, 0);
        step(0, 0, 0, 0, 0, 1, 0, C_NORM, S_RUN,  1, 4, 0);
        step(0, 0, 0, 0, 0, 1, 0, C_NORM, S_RUN,  1, 4, 0);
        // branch overrides stall and jump
        step(0, 1, 1, 1, 0, 1, 0, C_BR,   S_RUN,  1, 4, 0);
        step(0, 0, 0, 0, 0, 1, 0, C_NORM, S_RUN,  1, 4, 1);
        // five freeze cycles with a pending branch, then release
        step(0, 0, 0, 1, 1, 1, 0, C_FRZ,  S_RUN,  1, 4, 1);
        step(0, 0, 0, 1, 1, 1, 0, C_FRZ,  S_FRZ,  1, 5, 1);
        step(0, 0, 0, 1, 1, 1, 0, C_FRZ,  S_FRZ,  1, 6, 1);
        step(0, 0, 0, 1, 1, 1, 0, C_FRZ,  S_FRZ,  1, 7, 1);
        step(0, 0, 0, 1, 1, 1, 0, C_FRZ,  S_FRZ,  1, 8, 1);
        step(0, 0, 0, 1, 0, 1, 0, C_BR,   S_FRZ,  1, 9, 1);
        step(0, 0, 0, 0, 0, 1, 0, C_NORM, S_RUN,  1, 9, 2);
        // jump alone
        step(0, 0, 1, 0, 0, 1, 0, C_JMP,  S_RUN,  1, 9, 2);
        step(0, 0, 0, 0, 0, 1, 0, C_NORM, S_RUN,  1, 9, 3);
        // reset while frozen with stall_err set
        step(0, 0, 0, 0, 1, 1, 0, C_FRZ,  S_RUN,  1, 9, 3);
        step(1, 0, 0, 0, 1, 0, 0, C_FRZ,  S_FRZ,  1, 10, 3);
        step(0, 0, 0, 0, 0, 1, 0, C_BOOT, S_BOOT, 0, 0, 0);
        step(0, 0, 0, 0, 0, 1, 0, C_BOOT, S_BOOT, 0, 0, 0);
        // stall count holds across a freeze cycle: 2 + freeze + 2 stalls trips the limit
        step(0, 1, 0, 0, 0, 1, 0, C_STL,  S_RUN,  0, 0, 0);
        step(0, 1, 0, 0, 0, 1, 0, C_STL,  S_RUN,  0, 1, 0);
        step(0, 1, 0, 0, 1, 1, 0, C_FRZ,  S_RUN,  0, 2, 0);
        step(0, 1, 0, 0, 0, 1, 0, C_STL,  S_FRZ,  0, 3, 0);
        step(0, 1, 0, 0, 0, 1, 0, C_STL,  S_RUN,  0, 4, 0);
        step(0, 0, 0, 0, 0, 1, 0, C_NORM, S_RUN,  1, 5, 0);
        // redirect counter wraps from all-ones
        step(0, 0, 1, 0, 0, 1, 1, C_JMP,  S_RUN,  1, 5, 32'hFFFF_FFFF);
        step(0, 0, 0, 0, 0, 1, 0, C_NORM, S_RUN,  1, 5, 0);
        @(negedge clk);
        #1;
        check("queue_drain", vec_idx, 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
